instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 12 +
 rtl/fetch_buffer.sv | 50 +++++
 rtl/instruction_fetch.sv | 95 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the fetch slice: default widths and fetch FSM encoding.
package instruction_fetch_pkg;

  localparam int PROGRAM_COUNTER_WIDTH = 16;
  localparam int INSTR_WIDTH           = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction skid FIFO; head is visible the cycle after push.
// Clear empties it and wins over push/pop; push is dropped when full without a pop.
module fetch_buffer #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads and buffers results; first out_valid 2 cycles after first imem_req.
// Backpressure: out_ready low stops issue once buffered + in-flight reaches 2; flush empties the buffer and kills the in-flight read.
module instruction_fetch #(
  parameter int PROGRAM_COUNTER_WIDTH = instruction_fetch_pkg::PROGRAM_COUNTER_WIDTH,
  parameter int INSTR_WIDTH           = instruction_fetch_pkg::INSTR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             flush,
  input  logic [PROGRAM_COUNTER_WIDTH-1:0] pc,
  output logic                             pc_run,
  output logic                             imem_req,
  output logic [PROGRAM_COUNTER_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]           imem_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INSTR_WIDTH-1:0]           out_instr,
  output logic [PROGRAM_COUNTER_WIDTH-1:0] out_pc
);

  import instruction_fetch_pkg::*;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]           instr;
    logic [PROGRAM_COUNTER_WIDTH-1:0] pc;
  } fetch_entry_t;

  fetch_state_t                     state;
  fetch_state_t                     state_next;
  logic                             inflight;
  logic [PROGRAM_COUNTER_WIDTH-1:0] tag;
  logic [1:0]                       count;
  logic [2:0]                       occupancy;
  logic                             pop;
  logic                             push;
  fetch_entry_t                     push_entry;
  fetch_entry_t                     head;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  // A response arriving in a flush cycle belongs to the abandoned path.
  assign push      = inflight && !flush;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign pc_run    = imem_req || flush;

  assign push_entry = '{instr: imem_rdata, pc: tag};
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      state    <= state_next;
      inflight <= imem_req;
      if (imem_req) begin
        tag <= pc;
      end
    end
  end

  // out_ready reaches imem_req/pc_run combinationally so a draining slot is refilled without a bubble.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = FETCH;
      end
      FETCH: begin
        if (!enable) state_next = IDLE;
        imem_req = !rst && !flush && (occupancy < 3'd2);
      end
      default: state_next = IDLE;
    endcase
  end

  fetch_buffer #(
    .WIDTH($bits(fetch_entry_t))
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

endmodule
